// File: rtl/rx_chan_sequencer_if.sv
// Bus bundle for rx_chan_sequencer: sample inputs, serial register writes,
// FIFO write port and status/debug outputs.
interface rx_chan_sequencer_if #(
    parameter int LVL_W = 12
) ();
    logic              rxstrobe;
    logic [15:0]       ch_0;
    logic [15:0]       ch_1;
    logic [15:0]       ch_2;
    logic [15:0]       ch_3;
    logic [6:0]        serial_addr;
    logic [31:0]       serial_data;
    logic              serial_strobe;
    logic              clear_status;
    logic              fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic [31:0]       fifo_data;
    logic              fifo_wrreq;
    logic              have_pkt_rdy;
    logic              rx_overrun;
    logic [15:0]       debug_bus;

    modport master (
        output rxstrobe, ch_0, ch_1, ch_2, ch_3,
        output serial_addr, serial_data, serial_strobe, clear_status,
        output fifo_full, fifo_level,
        input  fifo_data, fifo_wrreq, have_pkt_rdy, rx_overrun, debug_bus
    );

    modport slave (
        input  rxstrobe, ch_0, ch_1, ch_2, ch_3,
        input  serial_addr, serial_data, serial_strobe, clear_status,
        input  fifo_full, fifo_level,
        output fifo_data, fifo_wrreq, have_pkt_rdy, rx_overrun, debug_bus
    );
endinterface

// File: rtl/rx_chan_sequencer.sv
// Receive channel sequencer: scans enabled channels after each rxstrobe and
// packs 16-bit samples pairwise into 32-bit receive FIFO words.
module rx_chan_sequencer #(
    parameter logic [6:0]  SER_ADDR  = 7'd40,
    parameter int unsigned PKT_WORDS = 2048,
    parameter int          LVL_W     = 12
) (
    input  logic rx_clk,
    input  logic reset,
    rx_chan_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;

    logic [15:0]      r_samp [4];
    logic [3:0]       r_shadow_mask;
    logic             r_shadow_en;
    logic             r_cfg_pending;
    logic [3:0]       r_act_mask;
    logic             r_act_en;
    logic             r_half_pend;
    logic [15:0]      r_half_data;
    logic [31:0]      r_fifo_data;
    logic             r_fifo_wrreq;
    logic             r_overrun;
    logic             r_pkt_rdy;

    logic             w_accept;
    logic             w_collision;
    logic             w_cfg_wr;
    logic             w_cfg_load;
    logic             w_take;
    logic [15:0]      w_sample;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;
    logic [26:0]      w_unused_cfg_bits;

    assign w_level           = bus.fifo_level;
    assign w_unused_cfg_bits = bus.serial_data[31:5];

    assign w_cfg_wr    = bus.serial_strobe && (bus.serial_addr == SER_ADDR);
    assign w_accept    = (r_state == ST_IDLE) && bus.rxstrobe && r_act_en && (r_act_mask != '0);
    // Config only swaps in on idle cycles that are not starting a sequence.
    assign w_cfg_load  = (r_state == ST_IDLE) && !w_accept && r_cfg_pending;
    assign w_collision = (r_state == ST_SEQ) && bus.rxstrobe;

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_take       = 1'b0;
        w_sample     = r_samp[r_idx];
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SEQ;
                    w_idx_next   = '0;
                end
            end
            ST_SEQ: begin
                w_take = r_act_mask[r_idx];
                w_drop = w_take && r_half_pend && bus.fifo_full;
                if (r_idx == 2'd3) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_samp[i] <= '0;
            end
            r_shadow_mask <= '0;
            r_shadow_en   <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_act_mask    <= '0;
            r_act_en      <= 1'b0;
            r_half_pend   <= 1'b0;
            r_half_data   <= '0;
            r_fifo_data   <= '0;
            r_fifo_wrreq  <= 1'b0;
            r_overrun     <= 1'b0;
            r_pkt_rdy     <= 1'b0;
        end else begin
            r_fifo_wrreq <= 1'b0;
            r_pkt_rdy    <= (32'(w_level) >= PKT_WORDS);

            if (w_accept) begin
                r_samp[0] <= bus.ch_0;
                r_samp[1] <= bus.ch_1;
                r_samp[2] <= bus.ch_2;
                r_samp[3] <= bus.ch_3;
            end

            if (w_cfg_load) begin
                r_act_mask    <= r_shadow_mask;
                r_act_en      <= r_shadow_en;
                r_cfg_pending <= 1'b0;
                r_half_pend   <= 1'b0;
            end

            // A write landing on a load cycle re-arms pending for the next idle cycle.
            if (w_cfg_wr) begin
                r_shadow_mask <= bus.serial_data[3:0];
                r_shadow_en   <= bus.serial_data[4];
                r_cfg_pending <= 1'b1;
            end

            if (w_take) begin
                if (!r_half_pend) begin
                    r_half_data <= w_sample;
                    r_half_pend <= 1'b1;
                end else begin
                    r_half_pend <= 1'b0;
                    if (!bus.fifo_full) begin
                        r_fifo_data  <= {r_half_data, w_sample};
                        r_fifo_wrreq <= 1'b1;
                    end
                end
            end

            if (w_collision || w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.fifo_data    = r_fifo_data;
    assign bus.fifo_wrreq   = r_fifo_wrreq;
    assign bus.rx_overrun   = r_overrun;
    assign bus.have_pkt_rdy = r_pkt_rdy;
    assign bus.debug_bus    = {4'b0000, r_act_en, r_act_mask, r_overrun,
                               r_fifo_wrreq, r_half_pend, r_idx, r_state};

endmodule

// File: tb/tb_rx_chan_sequencer.sv
// Self-checking bench for rx_chan_sequencer: expected FIFO words and their
// write cycles are queued at stimulus time and matched as writes appear.
module tb_rx_chan_sequencer;

    logic rx_clk = 1'b0;
    logic reset  = 1'b1;

    rx_chan_sequencer_if #(.LVL_W(12)) bus ();

    rx_chan_sequencer #(
        .SER_ADDR (7'd40),
        .PKT_WORDS(2048),
        .LVL_W    (12)
    ) dut (
        .rx_clk(rx_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    // One clock; outputs sampled on the falling edge, any write popped against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge rx_clk);
        @(negedge rx_clk);
        cyc++;
        if (bus.fifo_wrreq === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got word %h at cycle %0d, required no write", bus.fifo_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.fifo_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write_word: got %h at cycle %0d, required %h at cycle %0d",
                             bus.fifo_data, cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [31:0] d, input int unsigned c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input logic [4:0] v);
        bus.serial_addr   = 7'd40;
        bus.serial_data   = {27'h2AAAAAA, v};
        bus.serial_strobe = 1'b1;
        tick();
        bus.serial_strobe = 1'b0;
        bus.serial_addr   = 7'd0;
        bus.serial_data   = '0;
        tick();
    endtask

    task automatic strobe(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          output int unsigned t);
        bus.ch_0     = a;
        bus.ch_1     = b;
        bus.ch_2     = c;
        bus.ch_3     = d;
        bus.rxstrobe = 1'b1;
        t = cyc;
        tick();
        bus.rxstrobe = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned t;
        checks++;
        if (bus.fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b, required 0", bus.fifo_wrreq); end
        checks++;
        if (bus.fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 00000000", bus.fifo_data); end
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", bus.rx_overrun); end
        checks++;
        if (bus.have_pkt_rdy !== 1'b0) begin errors++; $display("FAIL reset_pkt_rdy: got %b, required 0", bus.have_pkt_rdy); end
        checks++;
        if (bus.debug_bus !== 16'h0) begin errors++; $display("FAIL reset_debug: got %h, required 0000", bus.debug_bus); end
        reset = 1'b0;
        tick();
        cfg_write(5'h1F);
        checks++;
        if (bus.debug_bus[11:7] !== 5'h1F) begin errors++; $display("FAIL cfg_active: got %h, required 1f", bus.debug_bus[11:7]); end
        strobe(16'h1111, 16'h2222, 16'h3333, 16'h4444, t);
        push(32'h11112222, t + 3);
        push(32'h33334444, t + 5);
        run(7);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d words outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b, required 0", bus.rx_overrun); end
    endtask

    task automatic test_odd_mask();
        int unsigned t;
        cfg_write(5'h15);
        strobe(16'h00A0, 16'hBAD1, 16'h00A2, 16'hBAD3, t);
        push(32'h00A000A2, t + 4);
        run(7);
        strobe(16'h00B0, 16'hBAD1, 16'h00B2, 16'hBAD3, t);
        push(32'h00B000B2, t + 4);
        run(7);
        cfg_write(5'h11);
        strobe(16'h00C0, 16'hBAD1, 16'hBAD2, 16'hBAD3, t);
        run(7);
        strobe(16'h00C1, 16'hBAD1, 16'hBAD2, 16'hBAD3, t);
        push(32'h00C000C1, t + 2);
        run(7);
        strobe(16'h00C2, 16'hBAD1, 16'hBAD2, 16'hBAD3, t);
        run(7);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL odd_missing: got %0d words outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (bus.debug_bus[4] !== 1'b1) begin errors++; $display("FAIL odd_half_pending: got %b, required 1", bus.debug_bus[4]); end
        cfg_write(5'h11);
        checks++;
        if (bus.debug_bus[4] !== 1'b0) begin errors++; $display("FAIL flush_half: got %b, required 0", bus.debug_bus[4]); end
        strobe(16'h00D0, 16'hBAD1, 16'hBAD2, 16'hBAD3, t);
        run(7);
        strobe(16'h00D1, 16'hBAD1, 16'hBAD2, 16'hBAD3, t);
        push(32'h00D000D1, t + 2);
        run(7);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_missing: got %0d words outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_collision();
        int unsigned t;
        cfg_write(5'h1F);
        strobe(16'h0101, 16'h0202, 16'h0303, 16'h0404, t);
        push(32'h01010202, t + 3);
        push(32'h03030404, t + 5);
        tick();
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL coll_before: got %b, required 0", bus.rx_overrun); end
        bus.ch_0 = 16'hEEE0; bus.ch_1 = 16'hEEE1; bus.ch_2 = 16'hEEE2; bus.ch_3 = 16'hEEE3;
        bus.rxstrobe = 1'b1;
        tick();
        bus.rxstrobe = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL coll_set: got %b at cycle t+%0d, required 1", bus.rx_overrun, cyc - t); end
        run(6);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL coll_missing: got %0d words outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b, required 1", bus.rx_overrun); end
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b, required 0", bus.rx_overrun); end
    endtask

    task automatic test_fifo_full();
        int unsigned t;
        bus.fifo_full = 1'b1;
        strobe(16'h5550, 16'h5551, 16'h5552, 16'h5553, t);
        run(6);
        checks++;
        if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL full_overrun: got %b, required 1", bus.rx_overrun); end
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL full_clear: got %b, required 0", bus.rx_overrun); end
        strobe(16'h6660, 16'h6661, 16'h6662, 16'h6663, t);
        tick();
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL full_set_wins: got %b, required 1", bus.rx_overrun); end
        run(4);
        bus.fifo_full = 1'b0;
        checks++;
        if (bus.debug_bus[4] !== 1'b0) begin errors++; $display("FAIL full_half_cleared: got %b, required 0", bus.debug_bus[4]); end
        bus.clear_status = 1'b1;
        tick();
        bus.clear_status = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned t;
        strobe(16'h7770, 16'h7771, 16'h7772, 16'h7773, t);
        push(32'h77707771, t + 3);
        push(32'h77727773, t + 5);
        run(4);
        strobe(16'h8880, 16'h8881, 16'h8882, 16'h8883, t);
        push(32'h88808881, t + 3);
        push(32'h88828883, t + 5);
        run(6);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d words outstanding, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, required 0", bus.rx_overrun); end
    endtask

    task automatic test_level();
        bus.fifo_level = 12'd2047;
        tick();
        checks++;
        if (bus.have_pkt_rdy !== 1'b0) begin errors++; $display("FAIL level_2047: got %b, required 0", bus.have_pkt_rdy); end
        bus.fifo_level = 12'd2048;
        checks++;
        if (bus.have_pkt_rdy !== 1'b0) begin errors++; $display("FAIL level_lag_rise: got %b, required 0", bus.have_pkt_rdy); end
        tick();
        checks++;
        if (bus.have_pkt_rdy !== 1'b1) begin errors++; $display("FAIL level_2048: got %b, required 1", bus.have_pkt_rdy); end
        bus.fifo_level = 12'd2047;
        checks++;
        if (bus.have_pkt_rdy !== 1'b1) begin errors++; $display("FAIL level_lag_fall: got %b, required 1", bus.have_pkt_rdy); end
        tick();
        checks++;
        if (bus.have_pkt_rdy !== 1'b0) begin errors++; $display("FAIL level_back_2047: got %b, required 0", bus.have_pkt_rdy); end
        bus.fifo_level = 12'd4095;
        tick();
        checks++;
        if (bus.have_pkt_rdy !== 1'b1) begin errors++; $display("FAIL level_4095: got %b, required 1", bus.have_pkt_rdy); end
        bus.fifo_level = 12'd0;
        tick();
    endtask

    task automatic test_disable_reset();
        int unsigned t;
        cfg_write(5'h0F);
        strobe(16'h9990, 16'h9991, 16'h9992, 16'h9993, t);
        checks++;
        if (bus.debug_bus[1:0] !== 2'd0) begin errors++; $display("FAIL disabled_state: got %0d, required 0", bus.debug_bus[1:0]); end
        run(6);
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL disabled_overrun: got %b, required 0", bus.rx_overrun); end
        cfg_write(5'h1F);
        bus.fifo_level = 12'd2048;
        strobe(16'hAAA0, 16'hAAA1, 16'hAAA2, 16'hAAA3, t);
        tick();
        checks++;
        if (bus.debug_bus[1:0] !== 2'd1) begin errors++; $display("FAIL mid_seq_state: got %0d, required 1", bus.debug_bus[1:0]); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.fifo_wrreq !== 1'b0) begin errors++; $display("FAIL async_wrreq: got %b, required 0", bus.fifo_wrreq); end
        checks++;
        if (bus.fifo_data !== 32'h0) begin errors++; $display("FAIL async_data: got %h, required 00000000", bus.fifo_data); end
        checks++;
        if (bus.have_pkt_rdy !== 1'b0) begin errors++; $display("FAIL async_pkt_rdy: got %b, required 0", bus.have_pkt_rdy); end
        checks++;
        if (bus.debug_bus !== 16'h0) begin errors++; $display("FAIL async_debug: got %h, required 0000", bus.debug_bus); end
        bus.fifo_level = 12'd0;
        run(2);
        reset = 1'b0;
        tick();
        strobe(16'hBBB0, 16'hBBB1, 16'hBBB2, 16'hBBB3, t);
        run(6);
        checks++;
        if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL post_reset_overrun: got %b, required 0", bus.rx_overrun); end
        checks++;
        if (bus.debug_bus !== 16'h0) begin errors++; $display("FAIL post_reset_disabled: got %h, required 0000", bus.debug_bus); end
    endtask

    initial begin
        bus.rxstrobe      = 1'b0;
        bus.ch_0          = '0;
        bus.ch_1          = '0;
        bus.ch_2          = '0;
        bus.ch_3          = '0;
        bus.serial_addr   = '0;
        bus.serial_data   = '0;
        bus.serial_strobe = 1'b0;
        bus.clear_status  = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_level    = '0;
        run(2);
        test_reset();
        test_odd_mask();
        test_collision();
        test_fifo_full();
        test_back_to_back();
        test_level();
        test_disable_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
